ula_pipe: RTL and testbench

Parametrised sequential ALU for the datapath, generalising the existing 8-bit combinational ALU. It adds configurable width, XOR and shift ops, an iterative multiplier, status flags, and a valid/ready handshake on both sides. It sits between the operand/decode stage (upstream) and register write-back (downstream), with one registered result slot.

---
 rtl/ula_pkg.sv | 30 +++
 rtl/ula_mul_iter.sv | 60 ++++++
 rtl/ula_pipe.sv | 183 ++++++++++++++++++
 tb/tb_ula_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared opcode, FSM-state and flag types for the ula_pipe ALU.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ula_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_SHR = 3'b111
  } ula_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ula_state_e;

  typedef struct packed {
    logic z;    // result zero (MUL: full product zero)
    logic c;    // carry out (ADD) / borrow (SUB)
    logic n;    // result MSB
    logic v;    // signed overflow
    logic err;  // illegal / unimplemented op
  } ula_flags_t;

endpackage

// File: rtl/ula_mul_iter.sv
// ula_mul_iter: iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Latency: start edge, then WIDTH busy cycles; done is high in the last one with product valid.
// Backpressure: none; the parent only pulses start while it can absorb the result.
//
// Ports: clk, rst_n; start (latch a/b, begin); a, b operands;
//        done (final cycle, product valid combinationally); product (2*WIDTH bits).
module ula_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_step;

  // The last partial product is folded in combinationally so the full
  // product is available in the same cycle done is asserted.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product  = acc_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= acc_step;
      mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q <= mplier_q >> 1;
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ula_pipe.sv
// ula_pipe: parametrised ALU with flags and a single registered result slot.
// Latency: 1 cycle for single-cycle ops; WIDTH+1 cycles for MUL (when ULA_MUL_EN is defined).
// Backpressure: in_ready drops while a result is held unconsumed or a multiply is in flight.
//
// Ports: clk, rst_n (async, active-low); in_valid/in_ready + a, b, op upstream;
//        out_valid/out_ready + result, result_hi, flag_z/c/n/v, err downstream.
// Build option: define ULA_MUL_EN to implement MUL (op 110); otherwise it returns err=1.
module ula_pipe
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  ula_op_e    op_e;
  ula_state_e state_q, state_d;

  logic             accept;
  logic             load_sc;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sc_res;
  ula_flags_t       sc_flags;

  logic             ld_vld;
  logic [WIDTH-1:0] ld_res;
  logic [WIDTH-1:0] ld_hi;
  ula_flags_t       ld_flags;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  ula_flags_t       flags_q;

  assign op_e     = ula_op_e'(op);
  assign in_ready = (state_q != BUSY) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Extra top bit carries the carry out of ADD and the borrow of SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

`ifdef ULA_MUL_EN
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = accept && (op_e == OP_MUL);
  assign load_sc   = accept && (op_e != OP_MUL);

  ula_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign load_sc   = accept;
`endif

  // Single-cycle datapath, evaluated on the operands presented at accept.
  always_comb begin
    sc_res   = '0;
    sc_flags = '0;
    unique case (op_e)
      OP_ADD: begin
        sc_res     = sum[WIDTH-1:0];
        sc_flags.c = sum[WIDTH];
        sc_flags.v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_res     = diff[WIDTH-1:0];
        sc_flags.c = diff[WIDTH];
        sc_flags.v = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      // The full b value is the shift amount; anything >= WIDTH clears the result.
      OP_SHL: if (b < WIDTH'(WIDTH)) sc_res = a << b;
      OP_SHR: if (b < WIDTH'(WIDTH)) sc_res = a >> b;
      OP_MUL: begin
`ifndef ULA_MUL_EN
        sc_flags.err = 1'b1;
`endif
      end
      default: ;
    endcase
    // An unimplemented MUL reports only err, even though its result is zero.
    if (op_e != OP_MUL) begin
      sc_flags.z = (sc_res == '0);
      sc_flags.n = sc_res[MSB];
    end
  end

  // Output-register load source: a single-cycle accept or a finishing multiply.
  // The two never coincide because in_ready is low while BUSY.
  always_comb begin
    ld_vld   = load_sc;
    ld_res   = sc_res;
    ld_hi    = '0;
    ld_flags = sc_flags;
`ifdef ULA_MUL_EN
    if (mul_done) begin
      ld_vld     = 1'b1;
      ld_res     = mul_prod[WIDTH-1:0];
      ld_hi      = mul_prod[2*WIDTH-1:WIDTH];
      ld_flags   = '0;
      ld_flags.z = (mul_prod == '0);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mul_start) state_d = BUSY;
      BUSY:    if (mul_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A load in the same cycle as a consume replaces the old result and keeps
  // out_valid high; otherwise a consume drops out_valid and data is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else if (ld_vld) begin
      out_valid_q <= 1'b1;
      result_q    <= ld_res;
      result_hi_q <= ld_hi;
      flags_q     <= ld_flags;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag_z    = flags_q.z;
  assign flag_c    = flags_q.c;
  assign flag_n    = flags_q.n;
  assign flag_v    = flags_q.v;
  assign err       = flags_q.err;

endmodule

// File: tb/tb_ula_pipe.sv
// tb_ula_pipe: scoreboard bench for ula_pipe (WIDTH=8), both with and without ULA_MUL_EN.
// Latency: checks 1-cycle single ops and WIDTH+1-cycle MUL.
// Backpressure: exercises hold-while-stalled and consume-plus-accept in one cycle.
module tb_ula_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       in_ready, out_valid;
  logic [7:0] result, result_hi;
  logic       flag_z, flag_c, flag_n, flag_v, err;

  int checks = 0;
  int errors = 0;

  // Observation layout: {result_hi, result, z, c, n, v, err}
  logic [20:0] sb[$];
  logic [20:0] obs_now;
  assign obs_now = {result_hi, result, flag_z, flag_c, flag_n, flag_v, err};

  ula_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int ua, ub, sa, sbv, r, hi, sv;
    bit z, c, n, v, e;
    ua = x; ub = y;
    sa  = (ua > 127) ? ua - 256 : ua;
    sbv = (ub > 127) ? ub - 256 : ub;
    r = 0; hi = 0; sv = 0; c = 0; v = 0; e = 0; z = 0; n = 0;
    case (o)
      3'd0: begin r = ua + ub; c = (r > 255); sv = sa + sbv; v = (sv > 127) || (sv < -128); end
      3'd1: begin r = ua - ub; c = (ua < ub); sv = sa - sbv; v = (sv > 127) || (sv < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (ub >= 8) ? 0 : (ua << ub);
      3'd6: begin
`ifdef ULA_MUL_EN
        r = ua * ub; hi = r / 256;
`else
        e = 1'b1;
`endif
      end
      default: r = (ub >= 8) ? 0 : (ua >> ub);
    endcase
    r = r & 255;
    if (o == 3'd6) begin
`ifdef ULA_MUL_EN
      z = (r == 0) && (hi == 0);
`endif
    end else begin
      z = (r == 0);
      n = (r > 127);
    end
    return {hi[7:0], r[7:0], z, c, n, v, e};
  endfunction

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, output bit ok);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) sb.push_back(model(o, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic get_out(output logic [20:0] obs, output int lat, output bit ok);
    ok = 1'b0; lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); lat++;
      if (out_valid) begin ok = 1'b1; break; end
    end
    obs = obs_now;
    if (ok) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, obs_now} !== 22'd0)
      begin errors++; $display("FAIL reset_outputs: got %h expected 0", {out_valid, obs_now}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_arith();
    logic [2:0] ops[5]  = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd1};
    logic [7:0] xs[5]   = '{8'hFF, 8'h80, 8'h01, 8'h7F, 8'h00};
    logic [7:0] ys[5]   = '{8'h01, 8'h01, 8'h02, 8'h01, 8'h00};
    logic [7:0] lres[5] = '{8'h00, 8'h7F, 8'hFF, 8'h80, 8'h00};
    logic [20:0] obs, exp;
    int lat;
    bit ok, got;
    for (int i = 0; i < 5; i++) begin
      send(ops[i], xs[i], ys[i], ok);
      get_out(obs, lat, got);
      checks++;
      if (!ok || !got) begin
        errors++; $display("FAIL arith_timeout[%0d]: accepted %b produced %b expected 1 1", i, ok, got);
      end else begin
        exp = sb.pop_front();
        if (obs !== exp) begin errors++; $display("FAIL arith[%0d]: got %h expected %h", i, obs, exp); end
        checks++;
        if (lat != 1) begin errors++; $display("FAIL arith_latency[%0d]: got %0d expected 1", i, lat); end
        checks++;
        if (obs[12:5] !== lres[i]) begin errors++; $display("FAIL arith_result[%0d]: got %h expected %h", i, obs[12:5], lres[i]); end
      end
    end
  endtask

  task automatic test_shift_logic();
    logic [2:0] ops[7]  = '{3'd5, 3'd7, 3'd5, 3'd7, 3'd2, 3'd3, 3'd4};
    logic [7:0] xs[7]   = '{8'h81, 8'h81, 8'h01, 8'h80, 8'hF0, 8'h0F, 8'hAA};
    logic [7:0] ys[7]   = '{8'h01, 8'h09, 8'h08, 8'h07, 8'h3C, 8'h30, 8'hFF};
    logic [7:0] lres[7] = '{8'h02, 8'h00, 8'h00, 8'h01, 8'h30, 8'h3F, 8'h55};
    logic [20:0] obs, exp;
    int lat;
    bit ok, got;
    for (int i = 0; i < 7; i++) begin
      send(ops[i], xs[i], ys[i], ok);
      get_out(obs, lat, got);
      checks++;
      if (!ok || !got) begin
        errors++; $display("FAIL shiftlogic_timeout[%0d]: accepted %b produced %b expected 1 1", i, ok, got);
      end else begin
        exp = sb.pop_front();
        if (obs !== exp) begin errors++; $display("FAIL shiftlogic[%0d]: got %h expected %h", i, obs, exp); end
        checks++;
        if (obs[12:5] !== lres[i]) begin errors++; $display("FAIL shiftlogic_result[%0d]: got %h expected %h", i, obs[12:5], lres[i]); end
      end
    end
  endtask

  task automatic test_mul();
    logic [7:0] xs[3] = '{8'd200, 8'd0, 8'd255};
    logic [7:0] ys[3] = '{8'd3, 8'd77, 8'd255};
    logic [20:0] obs, exp;
    int lat, exp_lat;
    bit ok, got, busy_rdy;
`ifdef ULA_MUL_EN
    exp_lat = 9;
`else
    exp_lat = 1;
`endif
    for (int i = 0; i < 3; i++) begin
      send(3'd6, xs[i], ys[i], ok);
      lat = 0; got = 1'b0; busy_rdy = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk); lat++;
        if (out_valid) begin got = 1'b1; break; end
        if (in_ready) busy_rdy = 1'b1;
      end
      obs = obs_now;
      checks++;
      if (!ok || !got) begin
        errors++; $display("FAIL mul_timeout[%0d]: accepted %b produced %b expected 1 1", i, ok, got);
      end else begin
        exp = sb.pop_front();
        if (obs !== exp) begin errors++; $display("FAIL mul[%0d]: got %h expected %h", i, obs, exp); end
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
        checks++;
        if (busy_rdy !== 1'b0) begin errors++; $display("FAIL mul_busy_ready[%0d]: got in_ready 1 expected 0", i); end
        if (i == 0) begin
          checks++;
`ifdef ULA_MUL_EN
          if (obs[20:5] !== 16'h0258) begin errors++; $display("FAIL mul_literal: got %h expected 0258", obs[20:5]); end
`else
          if ({obs[20:5], obs[0]} !== 17'h00001) begin errors++; $display("FAIL mul_disabled: got %h expected 00001", {obs[20:5], obs[0]}); end
`endif
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [20:0] held, exp;
    bit ok, got;
    send(3'd0, 8'h70, 8'h10, ok);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    held = obs_now;
    checks++;
    if (!ok || !got) begin
      errors++; $display("FAIL bp_timeout: accepted %b produced %b expected 1 1", ok, got);
    end else begin
      exp = sb.pop_front();
      if (held !== exp) begin errors++; $display("FAIL bp_first: got %h expected %h", held, exp); end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, obs_now} !== {1'b1, 1'b0, exp})
        begin errors++; $display("FAIL bp_hold[%0d]: got %h expected %h", k, {out_valid, in_ready, obs_now}, {1'b1, 1'b0, exp}); end
    end
    // Consume the held ADD and present an XOR in the same cycle.
    op = 3'd4; a = 8'hC3; b = 8'h5A; in_valid = 1'b1; out_ready = 1'b1;
    sb.push_back(model(3'd4, 8'hC3, 8'h5A));
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_on_consume: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    exp = sb.pop_front();
    checks++;
    if ({out_valid, obs_now} !== {1'b1, exp})
      begin errors++; $display("FAIL bp_xor: got %h expected %h", {out_valid, obs_now}, {1'b1, exp}); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [20:0] exp;
    logic [2:0] o;
    logic [7:0] x, y;
    int idx;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 21'h1FFFFF;
        checks++;
        if ({out_valid, obs_now} !== {1'b1, exp})
          begin errors++; $display("FAIL b2b[%0d]: got %h expected %h", i - 1, {out_valid, obs_now}, {1'b1, exp}); end
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready); end
      idx = $urandom_range(0, 6);
      o = (idx == 6) ? 3'd7 : idx[2:0];
      x = 8'($urandom_range(0, 255));
      y = (o == 3'd5 || o == 3'd7) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
      op = o; a = x; b = y; in_valid = 1'b1;
      sb.push_back(model(o, x, y));
    end
    @(negedge clk);
    in_valid = 1'b0;
    exp = (sb.size() > 0) ? sb.pop_front() : 21'h1FFFFF;
    checks++;
    if ({out_valid, obs_now} !== {1'b1, exp})
      begin errors++; $display("FAIL b2b_last: got %h expected %h", {out_valid, obs_now}, {1'b1, exp}); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    logic [20:0] obs, exp;
    int lat;
    bit ok, got, stray;
    send(3'd6, 8'd200, 8'd3, ok);
    sb.delete();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, obs_now} !== 22'd0)
      begin errors++; $display("FAIL midreset_outputs: got %h expected 0", {out_valid, obs_now}); end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin errors++; $display("FAIL midreset_stray_valid: got 1 expected 0"); end
    send(3'd0, 8'h01, 8'h01, ok);
    get_out(obs, lat, got);
    checks++;
    if (!ok || !got) begin
      errors++; $display("FAIL postreset_timeout: accepted %b produced %b expected 1 1", ok, got);
    end else begin
      exp = sb.pop_front();
      if (obs !== exp) begin errors++; $display("FAIL postreset_add: got %h expected %h", obs, exp); end
      checks++;
      if (obs[12:5] !== 8'h02) begin errors++; $display("FAIL postreset_result: got %h expected 02", obs[12:5]); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL postreset_latency: got %0d expected 1", lat); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_arith();
    test_shift_logic();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
